// File: rtl/spi_adc_responder.sv
// SPI responder (CPOL=1, CPHA=1) emulating a 12-bit serial ADC: streams {zeros, sample} MSB first on miso, captures mosi.
// Latency: pin-to-event SYNC_STAGES+1 clk; sample buffer is a one-entry valid/ready slot, frames never stall on it.
// Backpressure: sample_ready low while a sample is pending; an empty slot at frame start resends the last sample.
module spi_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_W-1:0]     sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  underrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0]  vld_sync_q, vld_sync_d;
    logic                    sck_prev_q, sck_prev_d;
    logic                    cs_prev_q, cs_prev_d;
    logic                    armed_q, armed_d;
    logic [DATA_W-1:0]       pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]       last_q, last_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [FRAME_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    miso_q, miso_d;
    logic                    miso_oe_q, miso_oe_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    frame_error_q, frame_error_d;
    logic                    underrun_q, underrun_d;

    logic                    sck_s, cs_s, mosi_s;
    logic                    sck_rise, sck_fall, cs_fall, cs_rise;
    logic                    load, start;
    logic [DATA_W-1:0]       sample_src;
    logic [FRAME_BITS-1:0]   frame_word;

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign cs_fall    = ~cs_s & cs_prev_q;
    assign cs_rise    = cs_s & ~cs_prev_q;
    assign load       = sample_valid & ~pend_vld_q;
    // armed_q blocks the fake cs fall produced when reset-forced sync flops drain a low pin.
    assign start      = (state_q == IDLE) & armed_q & cs_fall;
    assign sample_src = pend_vld_q ? pend_q : last_q;
    assign frame_word = FRAME_BITS'(sample_src);

    assign miso         = miso_q;
    assign miso_oe      = miso_oe_q;
    assign sample_ready = ~pend_vld_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign frame_done   = frame_done_q;
    assign frame_error  = frame_error_q;
    assign underrun     = underrun_q;
    assign busy         = (state_q == SHIFT);

    always_comb begin
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        vld_sync_d    = {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
        sck_prev_d    = sck_s;
        cs_prev_d     = cs_s;
        armed_d       = armed_q | (vld_sync_q[SYNC_STAGES-1] & cs_s);
        state_d       = state_q;
        pend_d        = pend_q;
        pend_vld_d    = pend_vld_q;
        last_d        = last_q;
        shreg_d       = shreg_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        bit_cnt_d     = bit_cnt_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        rx_valid_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        underrun_d    = 1'b0;

        // A same-cycle load keeps the slot full even though the frame start drains it.
        if (load) begin
            pend_d     = sample_data;
            pend_vld_d = 1'b1;
        end else if (start) begin
            pend_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SHIFT;
                    shreg_d    = frame_word;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    last_d     = sample_src;
                    underrun_d = ~pend_vld_q;
                    miso_oe_d  = 1'b1;
                    miso_d     = frame_word[FRAME_BITS-1];
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    if (bit_cnt_q == FULL_CNT) begin
                        rx_data_d    = rx_shift_q;
                        rx_valid_d   = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    if (sck_rise && (bit_cnt_q < FULL_CNT)) begin
                        rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                    if (sck_fall) begin
                        if ((bit_cnt_q != '0) && (bit_cnt_q < FULL_CNT)) begin
                            shreg_d = shreg_q << 1;
                            miso_d  = shreg_q[FRAME_BITS-2];
                        end else if (bit_cnt_q >= FULL_CNT) begin
                            miso_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sck_sync_q    <= '1;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            vld_sync_q    <= '0;
            sck_prev_q    <= 1'b1;
            cs_prev_q     <= 1'b1;
            armed_q       <= 1'b0;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
            last_q        <= '0;
            shreg_q       <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            bit_cnt_q     <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sck_sync_q    <= sck_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            vld_sync_q    <= vld_sync_d;
            sck_prev_q    <= sck_prev_d;
            cs_prev_q     <= cs_prev_d;
            armed_q       <= armed_d;
            pend_q        <= pend_d;
            pend_vld_q    <= pend_vld_d;
            last_q        <= last_d;
            shreg_q       <= shreg_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            bit_cnt_q     <= bit_cnt_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_valid_q    <= rx_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            underrun_q    <= underrun_d;
        end
    end

endmodule
